// File: rtl/dmem_load_ctrl.sv
// Load-side bridge from the MEM stage to the data-SRAM read sequencer: alignment check, held read, lane extract.
// Optional macro DMEM_LAST_WORD_CACHE_EN adds a one-entry last-word cache that bypasses the sequencer on a hit.
module dmem_load_ctrl #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int GAP_CYCLES     = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_req,
   input  logic [31:0] i_mem_addr,
   input  logic [2:0]  i_load_type,
   input  logic        i_dmem_wr,
   output logic        o_stall,
   output logic [31:0] o_load_data,
   output logic        o_load_valid,
   output logic        o_addr_err,
   output logic        o_read_ce,
   output logic [31:0] o_address,
   input  logic [31:0] i_rd_data,
   input  logic        i_rfin,
   output logic [2:0]  o_state
);
   // Handshakes: mem_req is held by the MEM stage until a load_valid or addr_err pulse;
   // read_ce is held with a stable address until the sequencer answers with a one-cycle rfin.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_DONE = 3'd2;
   localparam logic [2:0] S_ERR  = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   localparam logic [7:0] LP_T_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] LP_G_LAST = 3'(GAP_CYCLES - 1);

   logic [2:0]  r_state;
   logic [31:0] r_address;
   logic        r_read_ce;
   logic [2:0]  r_type;
   logic [1:0]  r_lane;
   logic [31:0] r_load_data;
   logic        r_load_valid;
   logic        r_addr_err;
   logic [7:0]  r_tcnt;
   logic [2:0]  r_gcnt;
   logic        r_timeout;
   logic        r_hit;
   logic        w_misalign;
   logic        w_hit;
   logic        w_stall;
   logic [31:0] w_hit_word;

   function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [2:0] ltype,
                                             input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (ltype)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {24'h0, b};
         3'b010:  return {{16{h[15]}}, h};
         3'b011:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   // Codes 101..111 behave as LW, so any type[2]=1 needs word alignment.
   assign w_misalign = (((i_load_type == 3'b010) || (i_load_type == 3'b011)) && i_mem_addr[0]) ||
                       (i_load_type[2] && (i_mem_addr[1:0] != 2'b00));

`ifdef DMEM_LAST_WORD_CACHE_EN
   logic [29:0] r_tag;
   logic        r_tag_vld;
   logic [31:0] r_cword;

   assign w_hit      = r_tag_vld && (r_tag == i_mem_addr[31:2]);
   assign w_hit_word = r_cword;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_tag     <= '0;
         r_tag_vld <= 1'b0;
         r_cword   <= '0;
      end else if (i_dmem_wr || (r_state == S_ERR)) begin
         r_tag_vld <= 1'b0;
      end else if ((r_state == S_WAIT) && i_rfin) begin
         r_tag     <= r_address[31:2];
         r_tag_vld <= 1'b1;
         r_cword   <= i_rd_data;
      end
   end
`else
   logic w_unused_dmem_wr;

   assign w_unused_dmem_wr = i_dmem_wr;
   assign w_hit            = 1'b0;
   assign w_hit_word       = '0;
`endif

   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         S_IDLE:  w_stall = i_mem_req && !w_misalign && !w_hit;
         S_WAIT:  w_stall = 1'b1;
         S_GAP:   w_stall = i_mem_req;
         default: w_stall = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_address    <= '0;
         r_read_ce    <= 1'b0;
         r_type       <= '0;
         r_lane       <= '0;
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
         r_addr_err   <= 1'b0;
         r_tcnt       <= '0;
         r_gcnt       <= '0;
         r_timeout    <= 1'b0;
         r_hit        <= 1'b0;
      end else begin
         r_load_valid <= 1'b0;
         r_addr_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_mem_req) begin
                  if (w_misalign) begin
                     r_state     <= S_ERR;
                     r_addr_err  <= 1'b1;
                     r_load_data <= '0;
                     r_timeout   <= 1'b0;
                  end else if (w_hit) begin
                     r_state      <= S_DONE;
                     r_load_valid <= 1'b1;
                     r_load_data  <= f_extract(w_hit_word, i_load_type, i_mem_addr[1:0]);
                     r_hit        <= 1'b1;
                  end else begin
                     r_state   <= S_WAIT;
                     r_read_ce <= 1'b1;
                     r_address <= {i_mem_addr[31:2], 2'b00};
                     r_type    <= i_load_type;
                     r_lane    <= i_mem_addr[1:0];
                     r_tcnt    <= '0;
                     r_hit     <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (i_rfin) begin
                  r_state      <= S_DONE;
                  r_read_ce    <= 1'b0;
                  r_load_valid <= 1'b1;
                  r_load_data  <= f_extract(i_rd_data, r_type, r_lane);
               end else if (r_tcnt == LP_T_LAST) begin
                  r_state     <= S_ERR;
                  r_read_ce   <= 1'b0;
                  r_addr_err  <= 1'b1;
                  r_load_data <= '0;
                  r_timeout   <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + 8'd1;
               end
            end
            S_DONE: begin
               r_state <= r_hit ? S_IDLE : S_GAP;
               r_gcnt  <= '0;
            end
            S_ERR: begin
               r_state <= r_timeout ? S_GAP : S_IDLE;
               r_gcnt  <= '0;
            end
            S_GAP: begin
               if (r_gcnt == LP_G_LAST) r_state <= S_IDLE;
               else                     r_gcnt  <= r_gcnt + 3'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Gated by reset so a held mem_req cannot re-freeze the pipeline while reset is low.
   assign o_stall      = w_stall && i_rst;
   assign o_load_data  = r_load_data;
   assign o_load_valid = r_load_valid;
   assign o_addr_err   = r_addr_err;
   assign o_read_ce    = r_read_ce;
   assign o_address    = r_address;
   assign o_state      = r_state;

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// Bench for dmem_load_ctrl: sequencer model, reference load model, scoreboard queue and monitor.
// Define DMEM_LAST_WORD_CACHE_EN for both files to exercise the last-word cache build.
module tb_dmem_load_ctrl;
   localparam int TO  = 15;
   localparam int GAP = 2;
`ifdef DMEM_LAST_WORD_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [2:0]  load_type = '0;
   logic        dmem_wr = 1'b0;
   logic [31:0] rd_data = '0;
   logic        rfin = 1'b0;
   logic        stall, load_valid, addr_err, read_ce;
   logic [31:0] load_data, address;
   logic [2:0]  unused_dbg_state;

   logic [31:0] mem [0:63];
   logic [32:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          issue_cyc = 0;
   int          seq_delay = 1;
   bit          seq_mute = 1'b0;
   int          n_reads = 0;
   bit          m_vld = 1'b0;
   logic [29:0] m_tag = '0;
   bit          snap_stall, snap_rce;
   logic [31:0] snap_data;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_load_ctrl #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
      .i_clk(clk), .i_rst(rst), .i_mem_req(mem_req), .i_mem_addr(mem_addr),
      .i_load_type(load_type), .i_dmem_wr(dmem_wr), .o_stall(stall),
      .o_load_data(load_data), .o_load_valid(load_valid), .o_addr_err(addr_err),
      .o_read_ce(read_ce), .o_address(address), .i_rd_data(rd_data), .i_rfin(rfin),
      .o_state(unused_dbg_state)
   );

   // Sequencer model: answers a held read_ce after seq_delay cycles unless muted.
   initial begin : seq
      int   cnt;
      logic prev;
      cnt  = 0;
      prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (read_ce && !prev) n_reads++;
         prev = read_ce;
         if (rfin) begin
            rfin    = 1'b0;
            rd_data = $urandom;
            cnt     = 0;
         end else if (read_ce && !seq_mute) begin
            cnt++;
            if (cnt >= seq_delay) begin
               rfin    = 1'b1;
               rd_data = mem[address[7:2]];
            end
         end else begin
            cnt = 0;
         end
      end
   end

   function automatic bit f_misaligned(input logic [31:0] a, input logic [2:0] t);
      if (t == 3'd2 || t == 3'd3) return (a % 2) != 0;
      if (t == 3'd0 || t == 3'd1) return 1'b0;
      return (a % 4) != 0;
   endfunction

   function automatic logic [31:0] f_ref(input logic [31:0] w, input logic [31:0] a, input logic [2:0] t);
      int unsigned lb, lh;
      int          v;
      lb = a % 4;
      lh = (a % 4) / 2;
      case (t)
         3'd0: begin v = int'((w >> (8 * lb)) & 32'hFF); if (v >= 128) v -= 256; return 32'(v); end
         3'd1: return (w >> (8 * lb)) & 32'hFF;
         3'd2: begin v = int'((w >> (16 * lh)) & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
         3'd3: return (w >> (16 * lh)) & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      mem[idx] = v;
      dmem_wr  = 1'b1;
      m_vld    = 1'b0;
      @(posedge clk); #1;
      dmem_wr  = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a, input logic [2:0] t, output bit hit);
      bit mis;
      mis = f_misaligned(a, t);
      hit = CACHE && !mis && m_vld && (m_tag == a[31:2]);
      if (mis) begin
         exp_q.push_back({1'b1, 32'h0});
         m_vld = 1'b0;
      end else if (hit) begin
         exp_q.push_back({1'b0, f_ref(mem[a[7:2]], a, t)});
      end else if (seq_mute) begin
         exp_q.push_back({1'b1, 32'h0});
         m_vld = 1'b0;
      end else begin
         exp_q.push_back({1'b0, f_ref(mem[a[7:2]], a, t)});
         m_vld = 1'b1;
         m_tag = a[31:2];
      end
      mem_addr  = a;
      load_type = t;
      mem_req   = 1'b1;
      issue_cyc = cyc;
   endtask

   task automatic wait_done(output int lat);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (load_valid || addr_err) begin
            seen       = 1'b1;
            snap_stall = stall;
            snap_rce   = read_ce;
            snap_data  = load_data;
         end
      end
      lat = cyc - issue_cyc;
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_done: no response after %0d cycles, expected load_valid or addr_err", lat);
      end
      @(posedge clk); #1;
      mem_req = 1'b0;
   endtask

   // Monitor: every completion pulse is matched against the head of the expected queue.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst && (load_valid || addr_err)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL resp_unexpected: got valid=%b err=%b data=%h, expected no response",
                     load_valid, addr_err, load_data);
         end else begin
            e = exp_q.pop_front();
            if ({load_valid, addr_err, load_data} !== {~e[32], e[32], e[31:0]}) begin
               n_err++;
               $display("FAIL resp: got valid=%b err=%b data=%h, expected valid=%b err=%b data=%h",
                        load_valid, addr_err, load_data, ~e[32], e[32], e[31:0]);
            end
         end
      end
   end

   initial begin
      int          lat, r0, d;
      bit          hit;
      logic [31:0] a;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_stall", 32'(stall), 0);
      check("rst_load_data", load_data, 0);
      check("rst_load_valid", 32'(load_valid), 0);
      check("rst_addr_err", 32'(addr_err), 0);
      check("rst_read_ce", 32'(read_ce), 0);
      check("rst_address", address, 0);
      @(posedge clk); #2; rst = 1'b1;
      idle(2);

      // LW 0x10, then a request arriving during GAP
      set_word(4, 32'h8899_AABB);
      seq_delay = 3;
      idle(3);
      issue(32'h10, 3'd4, hit);
      @(negedge clk);
      check("lw_stall_req_cycle", 32'(stall), 1);
      @(negedge clk);
      check("lw_read_ce", 32'(read_ce), 1);
      check("lw_address", address, 32'h10);
      wait_done(lat);
      check("lw_latency", lat, 32'(seq_delay + 1));
      check("lw_data", snap_data, 32'h8899_AABB);
      check("lw_done_stall", 32'(snap_stall), 0);
      check("lw_done_read_ce", 32'(snap_rce), 0);
      issue(32'h14, 3'd4, hit);
      for (int g = 0; g < GAP; g++) begin
         @(negedge clk);
         check("gap_read_ce", 32'(read_ce), 0);
         check("gap_stall", 32'(stall), 1);
      end
      wait_done(lat);

      // Lane extraction on 0x80FF_1234
      set_word(4, 32'h80FF_1234);
      issue(32'h13, 3'd0, hit); wait_done(lat);
      check("lb_0x13", snap_data, 32'hFFFF_FF80);
      issue(32'h13, 3'd1, hit); wait_done(lat);
      check("lbu_0x13", snap_data, 32'h0000_0080);
      issue(32'h12, 3'd2, hit); wait_done(lat);
      check("lh_0x12", snap_data, 32'hFFFF_80FF);

      // Misaligned LW
      idle(4);
      r0 = n_reads;
      issue(32'h6, 3'd4, hit);
      @(negedge clk);
      check("mis_stall", 32'(stall), 0);
      wait_done(lat);
      check("mis_latency", lat, 1);
      check("mis_stall_err", 32'(snap_stall), 0);
      check("mis_no_read", n_reads - r0, 0);

      // Timeout
      set_word(16, $urandom);
      idle(4);
      seq_mute = 1'b1;
      issue(32'h40, 3'd4, hit);
      wait_done(lat);
      check("to_latency", lat, 32'(TO + 1));
      check("to_data", snap_data, 0);
      check("to_stall", 32'(snap_stall), 0);
      check("to_read_ce", 32'(snap_rce), 0);
      for (int g = 0; g < GAP; g++) begin
         @(negedge clk);
         check("to_gap_read_ce", 32'(read_ce), 0);
      end
      seq_mute = 1'b0;

      // Asynchronous reset in WAIT
      set_word(12, $urandom);
      idle(4);
      seq_mute = 1'b1;
      issue(32'h30, 3'd4, hit);
      repeat (2) @(negedge clk);
      check("rw_read_ce_before", 32'(read_ce), 1);
      #2 rst = 1'b0;
      #1;
      check("rw_read_ce_after", 32'(read_ce), 0);
      check("rw_stall_after", 32'(stall), 0);
      void'(exp_q.pop_back());
      m_vld   = 1'b0;
      mem_req = 1'b0;
      @(posedge clk); #2;
      rst      = 1'b1;
      seq_mute = 1'b0;
      idle(2);
      seq_delay = 2;
      issue(32'h34, 3'd4, hit);
      wait_done(lat);
      check("rw_after_latency", lat, 32'(seq_delay + 1));
      check("rw_after_data", snap_data, mem[13]);

      // Repeated LW 0x20, with and without an intervening store
      seq_delay = 2;
      set_word(8, $urandom);
      idle(4);
      r0 = n_reads;
      issue(32'h20, 3'd4, hit); wait_done(lat);
      check("c1_latency", lat, 32'(seq_delay + 1));
      idle(4);
      issue(32'h20, 3'd4, hit);
      @(negedge clk);
      check("c2_stall", 32'(stall), CACHE ? 0 : 1);
      wait_done(lat);
      check("c2_latency", lat, CACHE ? 1 : 32'(seq_delay + 1));
      check("c2_reads", n_reads - r0, CACHE ? 1 : 2);
      set_word(8, mem[8]);
      idle(4);
      r0 = n_reads;
      issue(32'h20, 3'd4, hit); wait_done(lat);
      check("c3_latency", lat, 32'(seq_delay + 1));
      check("c3_reads", n_reads - r0, 1);

      // Random loads
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) == 0) set_word($urandom_range(0, 63), $urandom);
         d         = $urandom_range(1, 4);
         seq_delay = d;
         seq_mute  = ($urandom_range(0, 24) == 0);
         a         = 32'($urandom_range(0, 255));
         issue(a, 3'($urandom_range(0, 7)), hit);
         wait_done(lat);
         seq_mute = 1'b0;
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
      end

      idle(4);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_load_ctrl.md
Name: dmem_load_ctrl

Overview:
- Load-side bridge between the CPU MEM stage and the data-SRAM read sequencer.
- Accepts LB/LBU/LH/LHU/LW requests and checks alignment.
- Holds read_ce/address stable for the sequencer until its rfin pulse, then captures the word and extracts/extends the addressed lane.
- Stalls the pipeline for the duration, enforces a recovery gap between reads, and aborts on timeout.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles in WAIT without rfin before abort (4..255).
- GAP_CYCLES, 2: idle cycles with read_ce low after a read, letting the sequencer return to idle (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- mem_req  in  1  load request from MEM stage; held until load_valid or addr_err
- mem_addr  in  32  byte address
- load_type  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; other codes are treated as LW
- dmem_wr  in  1  store to data memory this cycle (used only by the optional feature)
- stall  out  1  freeze pipeline
- load_data  out  32  extracted/extended result; valid with load_valid
- load_valid  out  1  one-cycle completion pulse
- addr_err  out  1  one-cycle pulse: misaligned access or timeout
- read_ce  out  1  read enable to sequencer
- address  out  32  word address to sequencer: {mem_addr[31:2],2'b00}
- rd_data  in  32  sequencer data, valid while rfin=1
- rfin  in  1  sequencer completion pulse

Behaviour:
- Reset (rst=0, async) values: state IDLE; stall=0, load_data=0, load_valid=0, addr_err=0, read_ce=0, address=0; all counters 0.
- Misaligned access: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- IDLE:
  - mem_req and misaligned -> ERR. No read is issued and stall stays 0.
  - mem_req and aligned -> WAIT. address and a type/lane copy are registered. read_ce=1 from the next cycle.
  - stall is combinational: 1 in IDLE when mem_req is aligned, so the pipeline freezes in the same cycle as the request.
- WAIT:
  - read_ce=1 and address held constant; stall=1; the timeout counter increments each cycle.
  - rfin=1 -> capture rd_data into the lane extractor, then go to DONE. read_ce drops in the same registered update.
  - Counter reaches TIMEOUT_CYCLES without rfin -> ERR; read_ce drops.
- DONE: one cycle. load_valid=1, stall=0, load_data driven. Then -> GAP.
- ERR: one cycle. addr_err=1, load_data=0, stall=0. Then -> GAP on timeout, or -> IDLE on misalignment.
- GAP:
  - read_ce=0 for GAP_CYCLES cycles, then -> IDLE.
  - A mem_req arriving during GAP raises stall=1 and is not accepted until IDLE.
- Total latency for an aligned load: 1 (IDLE->WAIT) + sequencer cycles to rfin + 1 (DONE).
- Extraction (little-endian):
  - Byte lane k = rd_data[8k+7:8k], k = addr[1:0].
  - Half lane = addr[1] ? rd_data[31:16] : rd_data[15:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- rfin outside WAIT is ignored. dmem_wr is ignored unless the optional feature is compiled in.
- Reset mid-WAIT: read_ce=0 immediately and state=IDLE; the sequencer self-recovers.

Optional Feature:
- Macro: DMEM_LAST_WORD_CACHE_EN.
- With the macro defined:
  - A one-entry cache holds the last successfully read word (tag = address[31:2] plus valid bit).
  - An aligned mem_req in IDLE whose word address matches a valid tag goes directly to DONE on the next cycle. No read_ce, no GAP, and stall=0 in the request cycle.
  - dmem_wr=1 in any cycle clears the valid bit. An ERR also clears it.
  - Reset clears the valid bit.
- Without the macro: no tag storage, dmem_wr is unused, and every load goes through WAIT.

Test Plan:
- LW 0x0000_0010, sequencer asserts rfin with rd_data=0x8899_AABB -> read_ce high until rfin, address=0x10, load_valid pulse, load_data=0x8899_AABB, read_ce low for 2 cycles (GAP) after DONE.
- LB addr 0x13, rd_data=0x80FF_1234 -> load_data=0xFFFF_FF80. Same request as LBU -> 0x0000_0080. LH addr 0x12 -> 0xFFFF_80FF.
- LW addr 0x0000_0006 -> addr_err pulse in the cycle after request, read_ce never asserted, stall=0 throughout.
- rfin never arrives -> addr_err after 15 WAIT cycles, load_data=0, stall released, read_ce=0 for GAP.
- rst driven low during WAIT (asynchronous to clk) -> read_ce=0 and stall=0 before the next clk edge. A new LW after reset completes normally.
- With DMEM_LAST_WORD_CACHE_EN: LW 0x20 twice -> second request completes 1 cycle after issue with no read_ce. Repeat with dmem_wr pulsed between the two loads -> second load goes through WAIT.
